// File: rtl/posit_mult_pkg.sv
// Shared types and widths for the two-requester posit multiply scheduler.
package posit_mult_pkg;

    localparam int unsigned N      = 8;
    localparam int unsigned ES     = 3;
    localparam int unsigned RS     = $clog2(N);
    localparam int unsigned K_W    = RS + 1;
    localparam int unsigned TE_W   = ES + RS + 2;
    localparam int unsigned MANT_W = 2 * N;

    // Decoded posit operand; mant carries the hidden bit at its MSB.
    typedef struct packed {
        logic                  sign;
        logic                  inf;
        logic                  zero;
        logic signed [K_W-1:0] k;
        logic [ES-1:0]         exp;
        logic [N-1:0]          mant;
    } posit_dec_t;

    typedef struct packed {
        logic                   sign;
        logic                   inf;
        logic                   zero;
        logic signed [TE_W-1:0] total_exp;
        logic signed [K_W-1:0]  regime;
        logic [ES-1:0]          exp;
        logic [MANT_W-1:0]      mant;
    } posit_mres_t;

    // Combined scale {k,e} sign-extended to the total exponent width.
    function automatic logic signed [TE_W-1:0] scaled_exp(input logic signed [K_W-1:0] k,
                                                          input logic [ES-1:0] e);
        return {k[K_W-1], k, e};
    endfunction

endpackage

// File: rtl/posit_mult_core.sv
// Combinational posit multiply: sign, normalised mantissa product, combined exponent and regime.
module posit_mult_core
    import posit_mult_pkg::*;
(
    input  posit_dec_t  opa,
    input  posit_dec_t  opb,
    output posit_mres_t res
);

    logic [MANT_W-1:0]      prod;
    logic                   ovf;
    logic signed [TE_W-1:0] total_exp;
    logic [TE_W-2:0]        mag;
    logic [K_W-1:0]         mag_regime;

    always_comb begin
        res        = '0;
        prod       = MANT_W'(opa.mant) * MANT_W'(opb.mant);
        ovf        = prod[MANT_W-1];
        total_exp  = scaled_exp(opa.k, opa.exp) + scaled_exp(opb.k, opb.exp)
                   + $signed({{(TE_W-1){1'b0}}, ovf});
        mag        = (TE_W-1)'(total_exp[TE_W-1] ? unsigned'(-total_exp) : unsigned'(total_exp));
        mag_regime = mag[ES+RS:ES];
        // Non-negative scales, or negative ones with a fractional exponent part, round the regime up.
        if (!total_exp[TE_W-1] || (|mag[ES-1:0]))
            mag_regime = mag_regime + K_W'(1);

        res.inf  = opa.inf | opb.inf;
        res.zero = (opa.zero | opb.zero) & ~res.inf;
        if (!res.inf && !res.zero) begin
            res.sign      = opa.sign ^ opb.sign;
            res.total_exp = total_exp;
            res.regime    = signed'(mag_regime);
            res.exp       = total_exp[ES-1:0];
            res.mant      = ovf ? prod : {prod[MANT_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/posit_mult_scheduler.sv
// Round-robin sharing of one posit multiplier between two requesters, with a
// 2-stage elastic pipeline and per-requester outstanding-transaction limits.
module posit_mult_scheduler
    import posit_mult_pkg::*;
#(
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  posit_dec_t [1:0]       req_opa,
    input  posit_dec_t [1:0]       req_opb,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_tag,
    output logic                   res_sign,
    output logic                   res_inf,
    output logic                   res_zero,
    output logic signed [TE_W-1:0] res_total_exp,
    output logic signed [K_W-1:0]  res_regime,
    output logic [ES-1:0]          res_exp,
    output logic [MANT_W-1:0]      res_mant,
    output logic                   busy
);

    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0] cnt_q [2];
    logic             rr_ptr;
    logic             s1_valid, s1_tag;
    posit_dec_t       s1_opa, s1_opb;
    logic             s2_valid, s2_tag;
    posit_mres_t      s2_res, core_res;

    logic [1:0] elig, grant, accept, dec;
    logic       s1_free, s2_free, res_fire, acc_id;

    posit_mult_core u_core (
        .opa (s1_opa),
        .opb (s1_opb),
        .res (core_res)
    );

    // Arbitration and pipeline handshake.
    always_comb begin
        elig   = '0;
        grant  = '0;
        for (int i = 0; i < 2; i++)
            elig[i] = req_valid[i] && (cnt_q[i] < CNT_MAX);
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        s2_free   = !s2_valid || res_ready;
        s1_free   = !s1_valid || s2_free;
        req_ready = (reset || !s1_free) ? 2'b00 : grant;
        accept    = req_valid & req_ready;
        acc_id    = accept[1];
        res_fire  = s2_valid && res_ready;
        dec[0]    = res_fire && !s2_tag;
        dec[1]    = res_fire && s2_tag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= 1'b1;
            s1_valid <= 1'b0;
            s1_tag   <= 1'b0;
            s1_opa   <= '0;
            s1_opb   <= '0;
            s2_valid <= 1'b0;
            s2_tag   <= 1'b0;
            s2_res   <= '0;
            for (int i = 0; i < 2; i++)
                cnt_q[i] <= '0;
        end else begin
            if (|accept) begin
                s1_valid <= 1'b1;
                s1_tag   <= acc_id;
                s1_opa   <= req_opa[acc_id];
                s1_opb   <= req_opb[acc_id];
                rr_ptr   <= acc_id;
            end else if (s2_free) begin
                s1_valid <= 1'b0;
            end

            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_res <= core_res;
                    s2_tag <= s1_tag;
                end
            end

            for (int i = 0; i < 2; i++) begin
                if (accept[i] && !dec[i])
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                else if (!accept[i] && dec[i])
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end
    end

    assign res_valid     = s2_valid;
    assign res_tag       = s2_tag;
    assign res_sign      = s2_res.sign;
    assign res_inf       = s2_res.inf;
    assign res_zero      = s2_res.zero;
    assign res_total_exp = s2_res.total_exp;
    assign res_regime    = s2_res.regime;
    assign res_exp       = s2_res.exp;
    assign res_mant      = s2_res.mant;
    assign busy          = s1_valid | s2_valid | (|cnt_q[0]) | (|cnt_q[1]);

    // A result can only retire for a requester that has one outstanding.
    for (genvar g = 0; g < 2; g++) begin : g_cnt_chk
        a_no_underflow: assert property (@(posedge clk) disable iff (reset)
            dec[g] |-> (cnt_q[g] != '0));
        a_no_overflow: assert property (@(posedge clk) disable iff (reset)
            cnt_q[g] <= CNT_MAX);
    end

endmodule

// File: tb/tb_posit_mult_scheduler.sv
// Directed self-checking bench for posit_mult_scheduler.
module tb_posit_mult_scheduler;
    import posit_mult_pkg::*;

    localparam int unsigned RW = 4 + TE_W + K_W + ES + MANT_W;

    logic                   clk;
    logic                   reset;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    posit_dec_t [1:0]       req_opa;
    posit_dec_t [1:0]       req_opb;
    logic                   res_valid;
    logic                   res_ready;
    logic                   res_tag;
    logic                   res_sign;
    logic                   res_inf;
    logic                   res_zero;
    logic signed [TE_W-1:0] res_total_exp;
    logic signed [K_W-1:0]  res_regime;
    logic [ES-1:0]          res_exp;
    logic [MANT_W-1:0]      res_mant;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    posit_mult_scheduler #(.MAX_OUT(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opa       (req_opa),
        .req_opb       (req_opb),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_tag       (res_tag),
        .res_sign      (res_sign),
        .res_inf       (res_inf),
        .res_zero      (res_zero),
        .res_total_exp (res_total_exp),
        .res_regime    (res_regime),
        .res_exp       (res_exp),
        .res_mant      (res_mant),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic posit_dec_t mk(input logic s, input logic i, input logic z,
                                      input logic signed [K_W-1:0] k, input logic [ES-1:0] e,
                                      input logic [N-1:0] m);
        posit_dec_t d;
        d.sign = s; d.inf = i; d.zero = z; d.k = k; d.exp = e; d.mant = m;
        return d;
    endfunction

    function automatic logic [RW-1:0] got_fields();
        return {res_tag, res_sign, res_inf, res_zero, res_total_exp, res_regime, res_exp, res_mant};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 2'b11; res_ready = 1'b0;
        req_opa = '0; req_opb = '0;
        step(); step();
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b expected 00", req_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", res_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (got_fields() !== '0) begin errors++; $display("FAIL reset_data got %h expected 0", got_fields()); end
        step();
        reset = 1'b0; req_valid = 2'b00;
    endtask

    // One isolated transaction from requester id with hand-computed result fields.
    task automatic test_single(input logic id, input posit_dec_t a, input posit_dec_t b,
                               input logic [RW-1:0] exp_f);
        step();
        res_ready = 1'b1;
        req_valid = id ? 2'b10 : 2'b01;
        req_opa[id] = a; req_opb[id] = b;
        @(negedge clk);
        checks++; if (req_ready !== req_valid) begin errors++; $display("FAIL single_ready id=%0d got %b expected %b", id, req_ready, req_valid); end
        step();
        req_valid = 2'b00;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early id=%0d got %b expected 0", id, res_valid); end
        step();
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid id=%0d got %b expected 1", id, res_valid); end
        checks++; if (got_fields() !== exp_f) begin errors++; $display("FAIL single_fields id=%0d got %h expected %h", id, got_fields(), exp_f); end
        step();
        @(negedge clk);
        checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_drain id=%0d got %b expected 00", id, {res_valid, busy}); end
    endtask

    task automatic test_basic();
        // 1.0 x 1.0
        test_single(1'b0, mk(0,0,0,4'sd0,3'd0,8'h80), mk(0,0,0,4'sd0,3'd0,8'h80),
                    {1'b0, 1'b0, 1'b0, 1'b0, 8'sd0, 4'sd1, 3'd0, 16'h8000});
        // 1.5 x 1.5
        test_single(1'b1, mk(0,0,0,4'sd0,3'd0,8'hC0), mk(0,0,0,4'sd0,3'd0,8'hC0),
                    {1'b1, 1'b0, 1'b0, 1'b0, 8'sd1, 4'sd1, 3'd1, 16'h9000});
        // scale -1 x scale -1, mixed signs: total -2, fractional part present
        test_single(1'b0, mk(1,0,0,-4'sd1,3'd7,8'h80), mk(0,0,0,-4'sd1,3'd7,8'h80),
                    {1'b0, 1'b1, 1'b0, 1'b0, -8'sd2, 4'sd1, 3'd6, 16'h8000});
        // total -8: negative with no fractional part
        test_single(1'b1, mk(0,0,0,-4'sd1,3'd0,8'h80), mk(0,0,0,4'sd0,3'd0,8'h80),
                    {1'b1, 1'b0, 1'b0, 1'b0, -8'sd8, 4'sd1, 3'd0, 16'h8000});
        // 21 + 11 + overflow = 33, regime 5
        test_single(1'b1, mk(0,0,0,4'sd2,3'd5,8'hFF), mk(0,0,0,4'sd1,3'd3,8'hFF),
                    {1'b1, 1'b0, 1'b0, 1'b0, 8'sd33, 4'sd5, 3'd1, 16'hFE01});
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_rdy;
        logic [16:0] exp_tm;
        step();
        res_ready = 1'b1; req_valid = 2'b11;
        req_opa[0] = mk(0,0,0,4'sd0,3'd0,8'h80); req_opb[0] = mk(0,0,0,4'sd0,3'd0,8'h80);
        req_opa[1] = mk(0,0,0,4'sd0,3'd0,8'hC0); req_opb[1] = mk(0,0,0,4'sd0,3'd0,8'hC0);
        for (int c = 0; c < 6; c++) begin
            if (c == 4) req_valid = 2'b00;
            @(negedge clk);
            exp_rdy = (c >= 4) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready c=%0d got %b expected %b", c, req_ready, exp_rdy); end
            checks++; if (res_valid !== (c >= 2)) begin errors++; $display("FAIL b2b_valid c=%0d got %b expected %b", c, res_valid, (c >= 2)); end
            if (c >= 2) begin
                exp_tm = (c % 2 == 0) ? {1'b0, 16'h8000} : {1'b1, 16'h9000};
                checks++; if ({res_tag, res_mant} !== exp_tm) begin errors++; $display("FAIL b2b_tag_mant c=%0d got %h expected %h", c, {res_tag, res_mant}, exp_tm); end
            end
            step();
        end
    endtask

    task automatic test_max_out();
        logic [RW-1:0] exp_f;
        int n;
        exp_f = {1'b0, 1'b0, 1'b0, 1'b0, 8'sd0, 4'sd1, 3'd0, 16'hC000};
        step();
        res_ready = 1'b0; req_valid = 2'b01;
        req_opa[0] = mk(0,0,0,4'sd0,3'd0,8'hC0); req_opb[0] = mk(0,0,0,4'sd0,3'd0,8'h80);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL max_accept c=%0d got %b expected 01", c, req_ready); end
            step();
        end
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL max_limit c=%0d got %b expected 00", c, req_ready); end
            checks++; if ({res_valid, got_fields()} !== {1'b1, exp_f}) begin errors++; $display("FAIL max_stall c=%0d got %h expected %h", c, {res_valid, got_fields()}, {1'b1, exp_f}); end
            step();
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL max_prefire got %b expected 00", req_ready); end
        step();
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL max_freed got %b expected 01", req_ready); end
        n = res_valid ? 1 : 0;
        step();
        req_valid = 2'b00;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (res_valid) begin
                n++;
                checks++; if (got_fields() !== exp_f) begin errors++; $display("FAIL max_drain_fields c=%0d got %h expected %h", c, got_fields(), exp_f); end
            end
            step();
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL max_result_count got %0d expected 2", n); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL max_idle got %b expected 0", busy); end
    endtask

    task automatic test_specials();
        // NaR beats zero; every other field cleared
        test_single(1'b0, mk(1,1,0,4'sd2,3'd5,8'hC0), mk(0,0,1,4'sd0,3'd0,8'h80),
                    {1'b0, 1'b0, 1'b1, 1'b0, 8'sd0, 4'sd0, 3'd0, 16'h0000});
        test_single(1'b1, mk(1,0,1,4'sd0,3'd0,8'h80), mk(0,0,0,4'sd1,3'd2,8'hC0),
                    {1'b1, 1'b0, 1'b0, 1'b1, 8'sd0, 4'sd0, 3'd0, 16'h0000});
    endtask

    task automatic test_reset_mid();
        step();
        res_ready = 1'b0; req_valid = 2'b01;
        req_opa[0] = mk(0,0,0,4'sd0,3'd0,8'hC0); req_opb[0] = mk(0,0,0,4'sd0,3'd0,8'hC0);
        step(); step();
        req_valid = 2'b00; reset = 1'b1;
        @(negedge clk);
        checks++; if ({res_valid, busy} !== 2'b11) begin errors++; $display("FAIL rmid_inflight got %b expected 11", {res_valid, busy}); end
        step();
        @(negedge clk);
        checks++; if ({res_valid, busy, req_ready} !== 4'b0000) begin errors++; $display("FAIL rmid_cleared got %b expected 0000", {res_valid, busy, req_ready}); end
        checks++; if (got_fields() !== '0) begin errors++; $display("FAIL rmid_data got %h expected 0", got_fields()); end
        step();
        reset = 1'b0; res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL rmid_stale c=%0d got %b expected 00", c, {res_valid, busy}); end
            step();
        end
        req_valid = 2'b01;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_cnt_clear got %b expected 01", req_ready); end
        step();
        req_valid = 2'b00;
        step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_max_out();
        test_specials();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
